// File: rtl/nn_stream_pkg.sv
// Shared types and helpers for the neuron-layer streaming blocks.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//   idx_width()        : element index width, clog2 with a floor of 1
//   ser_state_t        : serializer FSM encoding (IDLE=0, SEND=1)
//   DEFAULT_DATA_WIDTH : default element width
package nn_stream_pkg;

  localparam int DEFAULT_DATA_WIDTH = 16;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_t;

  // A single-element vector still needs a 1-bit index port.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/stream_argmax.sv
// Signed running maximum over the beats of one streamed vector; ties keep the lowest index.
// Latency: result registered, max_valid pulses the cycle after the last beat.
// Backpressure: none of its own; only advances on beats qualified by the caller.
//   s_axi_aclk, reset : clock, synchronous active-high reset
//   beat, last        : a beat is transferred this cycle / it is the vector's final beat
//   idx, data         : index and value of the beat
//   max_valid         : one-cycle pulse when max_index/max_value are updated
//   max_index/value   : result of the last completed vector, held until the next pulse
module stream_argmax #(
  parameter int DATA_WIDTH = 16,
  parameter int IDX_W      = 1
) (
  input  logic                  s_axi_aclk,
  input  logic                  reset,
  input  logic                  beat,
  input  logic                  last,
  input  logic [IDX_W-1:0]      idx,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  max_valid,
  output logic [IDX_W-1:0]      max_index,
  output logic [DATA_WIDTH-1:0] max_value
);

  logic [DATA_WIDTH-1:0] run_val;
  logic [IDX_W-1:0]      run_idx;
  logic [DATA_WIDTH-1:0] cand_val;
  logic [IDX_W-1:0]      cand_idx;

  // Element 0 always seeds the running max so stale state from the previous
  // vector never leaks in. Strict '>' keeps the earliest index on ties.
  always_comb begin
    cand_val = run_val;
    cand_idx = run_idx;
    if (idx == '0 || $signed(data) > $signed(run_val)) begin
      cand_val = data;
      cand_idx = idx;
    end
  end

  always_ff @(posedge s_axi_aclk) begin
    if (reset) begin
      run_val   <= '0;
      run_idx   <= '0;
      max_valid <= 1'b0;
      max_index <= '0;
      max_value <= '0;
    end else begin
      max_valid <= 1'b0;
      if (beat) begin
        run_val <= cand_val;
        run_idx <= cand_idx;
        if (last) begin
          max_valid <= 1'b1;
          max_index <= cand_idx;
          max_value <= cand_val;
        end
      end
    end
  end

endmodule

// File: rtl/layer_stream_serializer.sv
// Captures a layer's parallel output vector and streams it one element per beat, with a one-deep pending buffer.
// Latency: first element presented the cycle after accept; back-to-back vectors stream with no bubble.
// Backpressure: out_ready stalls the stream with outputs held; in_ready drops while pending is full, and a vector offered then is dropped and flagged in overflow.
//   s_axi_aclk, reset  : clock, synchronous active-high reset
//   in_valid/in_data   : single-cycle vector pulse, element k at [k*DATA_WIDTH +: DATA_WIDTH]
//   in_ready           : pending buffer empty, a vector offered now will be taken
//   out_valid/out_ready: per-element handshake; out_data/out_index/out_last describe the beat
//   overflow           : sticky, a vector was dropped since reset
//   busy               : sending or holding a pending vector
// Optional: define SER_ARGMAX_EN to add max_valid/max_index/max_value (signed argmax per vector).
module layer_stream_serializer
  import nn_stream_pkg::*;
#(
  parameter int NUM_NEURONS = 30,
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  localparam int IDX_W      = idx_width(NUM_NEURONS)
) (
  input  logic                              s_axi_aclk,
  input  logic                              reset,
  input  logic                              in_valid,
  input  logic [NUM_NEURONS*DATA_WIDTH-1:0] in_data,
  output logic                              in_ready,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [DATA_WIDTH-1:0]             out_data,
  output logic [IDX_W-1:0]                  out_index,
  output logic                              out_last,
  output logic                              overflow,
  output logic                              busy
`ifdef SER_ARGMAX_EN
  ,
  output logic                              max_valid,
  output logic [IDX_W-1:0]                  max_index,
  output logic [DATA_WIDTH-1:0]             max_value
`endif
);

  localparam int VEC_W = NUM_NEURONS * DATA_WIDTH;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

  ser_state_t       state_q, state_d;
  logic [VEC_W-1:0] active_q, active_d;
  logic [VEC_W-1:0] pending_q, pending_d;
  logic             pend_full_q, pend_full_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             overflow_q;

  logic accept;
  logic beat;
  logic at_last;
  logic lastbeat;

  assign in_ready  = !pend_full_q;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == SEND);
  assign beat      = out_valid && out_ready;
  assign at_last   = (cnt_q == LAST_IDX);
  assign lastbeat  = beat && at_last;

  // The element on the wire is always the low slice of the shift register,
  // so a stalled beat holds naturally while nothing shifts.
  assign out_data  = active_q[DATA_WIDTH-1:0];
  assign out_index = cnt_q;
  assign out_last  = out_valid && at_last;
  assign overflow  = overflow_q;
  assign busy      = out_valid || pend_full_q;

  always_comb begin
    state_d     = state_q;
    active_d    = active_q;
    pending_d   = pending_q;
    pend_full_d = pend_full_q;
    cnt_d       = cnt_q;

    case (state_q)
      IDLE: begin
        // Pending is always empty here: it only fills during SEND and is
        // drained into active before SEND can exit.
        if (accept) begin
          active_d = in_data;
          cnt_d    = '0;
          state_d  = SEND;
        end
      end

      SEND: begin
        if (lastbeat) begin
          // Refill active in the same edge so the next vector's element 0
          // follows the last beat with no idle cycle.
          if (pend_full_q) begin
            active_d    = pending_q;
            cnt_d       = '0;
            pend_full_d = 1'b0;
          end else if (accept) begin
            active_d = in_data;
            cnt_d    = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          if (beat) begin
            active_d = active_q >> DATA_WIDTH;
            cnt_d    = cnt_q + IDX_W'(1);
          end
          if (accept) begin
            pending_d   = in_data;
            pend_full_d = 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge s_axi_aclk) begin
    if (reset) begin
      state_q     <= IDLE;
      active_q    <= '0;
      pending_q   <= '0;
      pend_full_q <= 1'b0;
      cnt_q       <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      active_q    <= active_d;
      pending_q   <= pending_d;
      pend_full_q <= pend_full_d;
      cnt_q       <= cnt_d;
      // A vector offered while pending is occupied is lost; remember it.
      if (in_valid && !in_ready) begin
        overflow_q <= 1'b1;
      end
    end
  end

`ifdef SER_ARGMAX_EN
  stream_argmax #(
    .DATA_WIDTH(DATA_WIDTH),
    .IDX_W     (IDX_W)
  ) u_argmax (
    .s_axi_aclk(s_axi_aclk),
    .reset     (reset),
    .beat      (beat),
    .last      (lastbeat),
    .idx       (cnt_q),
    .data      (out_data),
    .max_valid (max_valid),
    .max_index (max_index),
    .max_value (max_value)
  );
`endif

endmodule

// File: tb/tb_layer_stream_serializer.sv
// Scoreboard bench for layer_stream_serializer (NUM_NEURONS=4, DATA_WIDTH=16).
// Stimulus pushes the expected beats of every accepted vector; a negedge monitor pops and compares.
// Argmax outputs are checked as well when SER_ARGMAX_EN is defined.
module tb_layer_stream_serializer;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int IW = 2;

  typedef struct {
    logic [DW-1:0] data;
    logic [IW-1:0] idx;
    logic          last;
  } beat_t;

  typedef struct {
    logic [IW-1:0] idx;
    logic [DW-1:0] val;
  } amax_t;

  logic            s_axi_aclk = 1'b0;
  logic            reset      = 1'b1;
  logic            in_valid   = 1'b0;
  logic [N*DW-1:0] in_data    = '0;
  logic            out_ready  = 1'b0;
  logic            in_ready;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic [IW-1:0]   out_index;
  logic            out_last;
  logic            overflow;
  logic            busy;
`ifdef SER_ARGMAX_EN
  logic            max_valid;
  logic [IW-1:0]   max_index;
  logic [DW-1:0]   max_value;
`endif

  layer_stream_serializer #(
    .NUM_NEURONS(N),
    .DATA_WIDTH (DW)
  ) dut (
    .s_axi_aclk(s_axi_aclk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_index (out_index),
    .out_last  (out_last),
    .overflow  (overflow),
    .busy      (busy)
`ifdef SER_ARGMAX_EN
    ,
    .max_valid (max_valid),
    .max_index (max_index),
    .max_value (max_value)
`endif
  );

  always #5 s_axi_aclk = ~s_axi_aclk;

  int    checks = 0;
  int    errors = 0;
  int    n_out  = 0;      // vectors accepted but not yet fully delivered
  bit    exp_in_ready = 1'b1;
  bit    exp_busy     = 1'b0;
  bit    ovf_now      = 1'b0;
  bit    ovf_next     = 1'b0;
  beat_t exp_q[$];
  amax_t amax_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [N*DW-1:0] vec4(input logic [DW-1:0] e0, input logic [DW-1:0] e1,
                                          input logic [DW-1:0] e2, input logic [DW-1:0] e3);
    return {e3, e2, e1, e0};
  endfunction

  function automatic amax_t ref_argmax(input logic [N*DW-1:0] v);
    amax_t r;
    r.idx = '0;
    r.val = v[DW-1:0];
    for (int k = 1; k < N; k++) begin
      if ($signed(v[k*DW +: DW]) > $signed(r.val)) begin
        r.idx = IW'(k);
        r.val = v[k*DW +: DW];
      end
    end
    return r;
  endfunction

  // One clock cycle of stimulus. The vector is in flight-accepted only while
  // fewer than two vectors are outstanding (one sending, one waiting).
  task automatic drive(input bit v, input logic [N*DW-1:0] d, input bit rdy);
    beat_t b;
    @(posedge s_axi_aclk);
    #1;
    exp_in_ready = (n_out < 2);
    exp_busy     = (n_out > 0);
    ovf_now      = ovf_next;
    in_valid     = v;
    in_data      = d;
    out_ready    = rdy;
    if (v) begin
      if (n_out < 2) begin
        n_out++;
        for (int k = 0; k < N; k++) begin
          b.data = d[k*DW +: DW];
          b.idx  = IW'(k);
          b.last = (k == N - 1);
          exp_q.push_back(b);
        end
        amax_q.push_back(ref_argmax(d));
      end else begin
        ovf_next = 1'b1;
      end
    end
  endtask

  task automatic do_reset();
    @(posedge s_axi_aclk);
    #1;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    exp_q.delete();
    amax_q.delete();
    n_out    = 0;
    ovf_now  = 1'b0;
    ovf_next = 1'b0;
    repeat (2) @(posedge s_axi_aclk);
    #1;
    reset        = 1'b0;
    exp_in_ready = 1'b1;
    exp_busy     = 1'b0;
    @(negedge s_axi_aclk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_index", 32'(out_index), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && exp_q.size() > 0; i++) begin
      drive(1'b0, '0, 1'b1);
    end
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain_timeout actual=%0d beats outstanding required=0", exp_q.size());
    end
    repeat (2) drive(1'b0, '0, 1'b1);
  endtask

  // Monitor: compares handshake state and every transferred beat.
  initial begin
    beat_t         e;
    amax_t         m;
    bit            held = 1'b0;
    bit            max_due = 1'b0;
    logic [DW-1:0] h_data;
    logic [IW-1:0] h_idx;
    logic          h_last;
    forever begin
      @(negedge s_axi_aclk);
      if (reset) begin
        held    = 1'b0;
        max_due = 1'b0;
      end else begin
        chk("in_ready", 32'(in_ready), 32'(exp_in_ready));
        chk("busy", 32'(busy), 32'(exp_busy));
        chk("out_valid", 32'(out_valid), 32'(exp_busy));
        chk("overflow", 32'(overflow), 32'(ovf_now));
        if (held) begin
          chk("stall_data", 32'(out_data), 32'(h_data));
          chk("stall_index", 32'(out_index), 32'(h_idx));
          chk("stall_last", 32'(out_last), 32'(h_last));
        end
`ifdef SER_ARGMAX_EN
        chk("max_valid", 32'(max_valid), 32'(max_due));
        if (max_due) begin
          if (amax_q.size() == 0) begin
            errors++;
            $display("FAIL argmax_underflow actual=pulse required=no_pending_result");
          end else begin
            m = amax_q.pop_front();
            chk("max_index", 32'(max_index), 32'(m.idx));
            chk("max_value", 32'(max_value), 32'(m.val));
          end
        end
`endif
        max_due = 1'b0;
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL extra_beat actual=data %0h idx %0d required=no_beat", out_data, out_index);
          end else begin
            e = exp_q.pop_front();
            chk("beat_data", 32'(out_data), 32'(e.data));
            chk("beat_index", 32'(out_index), 32'(e.idx));
            chk("beat_last", 32'(out_last), 32'(e.last));
            if (e.last) begin
              n_out--;
              max_due = 1'b1;
            end
          end
        end
        held   = out_valid && !out_ready;
        h_data = out_data;
        h_idx  = out_index;
        h_last = out_last;
      end
    end
  end

  initial begin
    logic [N*DW-1:0] va;
    logic [N*DW-1:0] vb;
    logic [N*DW-1:0] vr;
    va = vec4(16'h0001, 16'h0002, 16'h0003, 16'h0004);
    vb = vec4(16'h0010, 16'h0020, 16'h0030, 16'h0040);

    do_reset();

    // Basic stream with downstream always ready.
    drive(1'b1, va, 1'b1);
    repeat (6) drive(1'b0, '0, 1'b1);

    // Back-pressure on elements 1..2.
    drive(1'b1, va, 1'b1);
    drive(1'b0, '0, 1'b1);
    drive(1'b0, '0, 1'b0);
    drive(1'b0, '0, 1'b0);
    repeat (6) drive(1'b0, '0, 1'b1);

    // Second vector lands in pending and follows with no bubble.
    drive(1'b1, va, 1'b1);
    drive(1'b0, '0, 1'b1);
    drive(1'b1, vb, 1'b1);
    repeat (9) drive(1'b0, '0, 1'b1);

    // Third vector offered while pending is full is dropped.
    drive(1'b1, va, 1'b1);
    drive(1'b0, '0, 1'b1);
    drive(1'b1, vb, 1'b1);
    drive(1'b1, vec4(16'hdead, 16'hbeef, 16'hcafe, 16'hf00d), 1'b1);
    drain();
    do_reset();

    // Reset in the middle of a send with a pending vector.
    drive(1'b1, va, 1'b1);
    drive(1'b0, '0, 1'b1);
    drive(1'b1, vb, 1'b1);
    drive(1'b0, '0, 1'b1);
    do_reset();
    drive(1'b1, vb, 1'b1);
    drain();

    // Signed maximum with a tie and a most-negative element.
    drive(1'b1, vec4(16'hfffe, 16'h0005, 16'h0005, 16'h8000), 1'b1);
    drive(1'b0, '0, 1'b1);
    drive(1'b1, vec4(16'h8000, 16'hffff, 16'h8001, 16'hffff), 1'b1);
    drain();

    // Randomized traffic, including overflow and stalls.
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < N; k++) begin
        vr[k*DW +: DW] = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 3)) : DW'($urandom);
      end
      drive(($urandom_range(0, 5) == 0), vr, ($urandom_range(0, 3) != 0));
    end
    drain();
    do_reset();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/layer_stream_serializer.md
Name: layer_stream_serializer

Overview:
- Parametrised successor to the per-layer hold/shift/send stage between neuron layers.
- Captures one layer's parallel output vector (NUM_NEURONS x DATA_WIDTH) on a valid pulse and streams it one element per beat to the next layer.
- Adds ready/valid back-pressure, a one-deep pending buffer so a new vector arriving mid-send is not lost, last/index sideband, and a sticky overflow flag.
- Emits exactly NUM_NEURONS beats per vector.

Parameters:
- NUM_NEURONS, 30, elements per input vector (>=1).
- DATA_WIDTH, 16, bits per element.
- IDX_W, max(1,clog2(NUM_NEURONS)), width of the element index (derived, not overridden).

Ports:
- s_axi_aclk  in  1  clock
- reset  in  1  synchronous, active-high reset; clock s_axi_aclk
- in_valid  in  1  single-cycle pulse, vector present on in_data
- in_data  in  NUM_NEURONS*DATA_WIDTH  element k at bits [k*DATA_WIDTH +: DATA_WIDTH]
- in_ready  out  1  pending buffer empty; vector will be accepted
- out_valid  out  1  out_data holds a valid element
- out_ready  in  1  downstream accepts beat
- out_data  out  DATA_WIDTH  current element
- out_index  out  IDX_W  index of current element
- out_last  out  1  high on beat with index NUM_NEURONS-1
- overflow  out  1  sticky: a vector was dropped
- busy  out  1  state==SEND or pending full

Behaviour:
- Reset: state IDLE, pending empty, out_valid=0, out_index=0, out_last=0, overflow=0, busy=0, in_ready=1. out_data resets to 0.
- Reset asserted mid-operation aborts the send and discards pending. Outputs hold reset values from the next edge; no partial beats follow.
- Storage: active shift register, pending register, element counter cnt (0..NUM_NEURONS-1).
- in_ready = !pending_full (combinational). Accept = in_valid && in_ready.
- Beat = out_valid && out_ready. lastbeat = beat && cnt==NUM_NEURONS-1.
- IDLE state:
  - Accept loads active and sets cnt=0, state=SEND.
  - out_valid rises the cycle after accept (latency 1), carrying element 0.
- SEND state:
  - out_valid=1. out_data = active[DATA_WIDTH-1:0]. out_index=cnt. out_last=(cnt==NUM_NEURONS-1).
  - On a non-last beat: shift active right by DATA_WIDTH, cnt++.
  - With out_ready=0, out_data/out_index/out_last must stay stable.
- End of vector (lastbeat):
  - Pending full: move pending into active, cnt=0, clear pending, stay SEND. No bubble: element 0 of the next vector is presented the following cycle.
  - Pending empty and accept in the same cycle: load in_data straight into active, stay SEND, no bubble.
  - Otherwise: go to IDLE; out_valid=0 next cycle.
- Accept in SEND without lastbeat: store in pending.
- in_valid while in_ready=0: vector dropped, overflow set until reset. Active and pending are unaffected.
- NUM_NEURONS=1: every beat is last; cnt stays 0.
- Elements are passed bit-exact; no arithmetic on the data path.

Optional Feature:
- SER_ARGMAX_EN defined:
  - Adds outputs max_valid (1), max_index (IDX_W) and max_value (DATA_WIDTH).
  - Tracks a signed running maximum over beats of each vector.
  - Ties keep the lowest index.
  - max_valid pulses one cycle after each lastbeat. max_index/max_value hold until the next pulse.
  - All three reset to 0.
- Undefined: these ports and the logic do not exist; behaviour otherwise identical.

Decomposition:
- Shared package nn_stream_pkg:
  - idx width function (clog2 with minimum 1).
  - state encoding IDLE=0, SEND=1.
  - default DATA_WIDTH constant.
- One natural sub-module: stream_argmax (running compare/hold), instantiated only under SER_ARGMAX_EN.

Test Plan:
- Basic: NUM_NEURONS=4, DATA_WIDTH=16, out_ready=1; pulse in_data elements {0x0001,0x0002,0x0003,0x0004} at cycle 10 -> out_valid cycles 11-14, data 1,2,3,4, index 0-3, out_last only at cycle 14; out_valid=0 at cycle 15.
- Back-pressure: same vector, out_ready low on cycles 12-13 -> element 2 held stable cycles 12-14; exactly 4 beats total; order preserved.
- Pending, no bubble: second vector {0x10,0x20,0x30,0x40} pulsed at cycle 12 -> in_ready=0 cycles 13-14; beats 1,2,3,4,0x10,0x20,0x30,0x40 on consecutive cycles 11-18.
- Overflow: third vector pulsed while pending full -> vector dropped, overflow=1 and stays 1; first two vectors stream unchanged; reset clears overflow.
- Reset mid-send: assert reset after beat 2 of a vector with pending full -> next cycle out_valid=0, busy=0, in_ready=1; a fresh vector afterwards streams from index 0.
- SER_ARGMAX_EN: vector {0xFFFE,0x0005,0x0005,0x8000} (signed) -> max_valid one cycle after last beat, max_index=1, max_value=0x0005.
